// File: rtl/butterfly_core_pipelined.sv
// butterfly_core_pipelined
//
// One shared, fully pipelined radix-2 DIT butterfly that serves every FFT
// stage. It takes one beat per cycle with no backpressure and produces
// A' = A + B*W and B' = A - B*W four cycles later.
//
// Each beat carries its own stage number, scale mask and direction.
// Per-stage divide-by-2 scaling halves the results of the selected stages.
// Inverse mode uses the conjugate twiddle.
//
// Build option (macro BUTTERFLY_SAT_EN):
//   defined   - results outside the FFT_DW range saturate.
//   undefined - results outside the FFT_DW range wrap (two's complement).
//   In both builds the sticky overflow flag reports out-of-range results.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   fft_stage               stage of the current beat (sampled with iact)
//   scale_mask              bit s set: halve the outputs of stage s
//   inverse                 1 = conjugate the twiddle (IFFT)
//   clear_flags             synchronous clear of the sticky flags
//   iact                    input beat valid
//   ictrl                   2-bit sideband, delivered on octrl
//   input_memory_address    delivered on output_memory_address
//   input_A, input_B        {imag, real} operands
//   twiddle_real/imag       twiddle for the same beat
//   oact                    output beat valid
//   octrl                   delayed ictrl
//   output_memory_address   delayed address
//   output_A, output_B      {imag, real} results; held while oact=0
//   overflow                sticky: a result exceeded the FFT_DW range
//   stage_err               sticky: a beat arrived with fft_stage >= FFT_N
module butterfly_core_pipelined #(
  parameter int FFT_N          = 10,
  parameter int FFT_DW         = 16,
  parameter int STAGE_COUNT_BW = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [STAGE_COUNT_BW-1:0] fft_stage,
  input  logic [FFT_N-1:0]          scale_mask,
  input  logic                      inverse,
  input  logic                      clear_flags,
  input  logic                      iact,
  input  logic [1:0]                ictrl,
  input  logic [FFT_N-2:0]          input_memory_address,
  input  logic [2*FFT_DW-1:0]       input_A,
  input  logic [2*FFT_DW-1:0]       input_B,
  input  logic [FFT_DW-1:0]         twiddle_real,
  input  logic [FFT_DW-1:0]         twiddle_imag,
  output logic                      oact,
  output logic [1:0]                octrl,
  output logic [FFT_N-2:0]          output_memory_address,
  output logic [2*FFT_DW-1:0]       output_A,
  output logic [2*FFT_DW-1:0]       output_B,
  output logic                      overflow,
  output logic                      stage_err
);

  localparam int DW = FFT_DW;
  localparam int AW = FFT_N - 1;
  localparam int PW = 2 * FFT_DW;
  localparam int SW = 2 * FFT_DW + 1;
  localparam int RW = FFT_DW + 2;
  localparam int XW = FFT_DW + 3;

  localparam logic signed [SW-1:0] P_BIAS = SW'(1) << (FFT_DW - 2);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] MAX_X  = {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_X  = {{(XW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Optional halving (round half up), then narrowing to FFT_DW bits.
  // The MSB of the result reports whether the value was out of range.
  function automatic logic [FFT_DW:0] scale_narrow(input logic signed [XW-1:0] x,
                                                   input logic scale);
    logic signed [XW-1:0] v;
    logic hi;
    logic lo;
    v  = scale ? ((x + ONE_X) >>> 1) : x;
    hi = (v > MAX_X);
    lo = (v < MIN_X);
`ifdef BUTTERFLY_SAT_EN
    if (hi) begin
      v = MAX_X;
    end else if (lo) begin
      v = MIN_X;
    end
`endif
    return {hi | lo, v[FFT_DW-1:0]};
  endfunction

  // Stage check and scale-bit selection. The loop avoids indexing
  // scale_mask with an out-of-range stage number.
  logic stage_ok;
  logic stage_scale;
  always_comb begin
    stage_ok    = (fft_stage < STAGE_COUNT_BW'(FFT_N));
    stage_scale = 1'b0;
    for (int s = 0; s < FFT_N; s++) begin
      if (fft_stage == STAGE_COUNT_BW'(s)) begin
        stage_scale = scale_mask[s];
      end
    end
  end

  // S1: operand capture.
  // Conjugation is carried as the inverse bit and applied as a sign choice
  // when the products are summed. Negating a full-scale twiddle therefore
  // never needs an extra bit.
  logic                 s1_valid, s1_inv, s1_scale;
  logic [1:0]           s1_ctrl;
  logic [AW-1:0]        s1_addr;
  logic signed [DW-1:0] s1_ar, s1_ai, s1_br, s1_bi, s1_wr, s1_wi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      s1_scale <= 1'b0;
      s1_ctrl  <= '0;
      s1_addr  <= '0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
      s1_wr    <= '0;
      s1_wi    <= '0;
    end else begin
      s1_valid <= iact & stage_ok;
      s1_inv   <= inverse;
      s1_scale <= stage_scale;
      s1_ctrl  <= ictrl;
      s1_addr  <= input_memory_address;
      s1_ar    <= input_A[DW-1:0];
      s1_ai    <= input_A[2*DW-1:DW];
      s1_br    <= input_B[DW-1:0];
      s1_bi    <= input_B[2*DW-1:DW];
      s1_wr    <= twiddle_real;
      s1_wi    <= twiddle_imag;
    end
  end

  // S2: the four partial products.
  logic                 s2_valid, s2_inv, s2_scale;
  logic [1:0]           s2_ctrl;
  logic [AW-1:0]        s2_addr;
  logic signed [DW-1:0] s2_ar, s2_ai;
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_inv   <= 1'b0;
      s2_scale <= 1'b0;
      s2_ctrl  <= '0;
      s2_addr  <= '0;
      s2_ar    <= '0;
      s2_ai    <= '0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_inv   <= s1_inv;
      s2_scale <= s1_scale;
      s2_ctrl  <= s1_ctrl;
      s2_addr  <= s1_addr;
      s2_ar    <= s1_ar;
      s2_ai    <= s1_ai;
      s2_rr    <= PW'(s1_br) * PW'(s1_wr);
      s2_ii    <= PW'(s1_bi) * PW'(s1_wi);
      s2_ri    <= PW'(s1_br) * PW'(s1_wi);
      s2_ir    <= PW'(s1_bi) * PW'(s1_wr);
    end
  end

  // Complex product sums.
  // With the conjugate twiddle the sign of the wi terms flips:
  //   forward: Pr = rr - ii, Pi = ri + ir
  //   inverse: Pr = rr + ii, Pi = ir - ri
  // Both sums are then rounded back to the data scale.
  logic signed [SW-1:0] sum_r, sum_i;
  logic signed [RW-1:0] p_r_next, p_i_next;
  always_comb begin
    sum_r    = s2_inv ? (SW'(s2_rr) + SW'(s2_ii)) : (SW'(s2_rr) - SW'(s2_ii));
    sum_i    = s2_inv ? (SW'(s2_ir) - SW'(s2_ri)) : (SW'(s2_ri) + SW'(s2_ir));
    p_r_next = RW'((sum_r + P_BIAS) >>> (DW - 1));
    p_i_next = RW'((sum_i + P_BIAS) >>> (DW - 1));
  end

  // S3: rounded product, with A delayed alongside it.
  logic                 s3_valid, s3_scale;
  logic [1:0]           s3_ctrl;
  logic [AW-1:0]        s3_addr;
  logic signed [DW-1:0] s3_ar, s3_ai;
  logic signed [RW-1:0] s3_pr, s3_pi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_scale <= 1'b0;
      s3_ctrl  <= '0;
      s3_addr  <= '0;
      s3_ar    <= '0;
      s3_ai    <= '0;
      s3_pr    <= '0;
      s3_pi    <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_scale <= s2_scale;
      s3_ctrl  <= s2_ctrl;
      s3_addr  <= s2_addr;
      s3_ar    <= s2_ar;
      s3_ai    <= s2_ai;
      s3_pr    <= p_r_next;
      s3_pi    <= p_i_next;
    end
  end

  // S4: add/sub with one guard bit, then scaling and narrowing.
  logic signed [XW-1:0] ar_x, ai_x, pr_x, pi_x;
  logic [DW-1:0]        ya_r, ya_i, yb_r, yb_i;
  logic                 clip_ar, clip_ai, clip_br, clip_bi;
  logic                 any_clip;
  always_comb begin
    ar_x = XW'(s3_ar);
    ai_x = XW'(s3_ai);
    pr_x = XW'(s3_pr);
    pi_x = XW'(s3_pi);
    {clip_ar, ya_r} = scale_narrow(ar_x + pr_x, s3_scale);
    {clip_ai, ya_i} = scale_narrow(ai_x + pi_x, s3_scale);
    {clip_br, yb_r} = scale_narrow(ar_x - pr_x, s3_scale);
    {clip_bi, yb_i} = scale_narrow(ai_x - pi_x, s3_scale);
    any_clip = clip_ar | clip_ai | clip_br | clip_bi;
  end

  // Output registers. Data and sideband load only on a valid beat, so they
  // hold their last values while oact is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oact                  <= 1'b0;
      octrl                 <= '0;
      output_memory_address <= '0;
      output_A              <= '0;
      output_B              <= '0;
    end else begin
      oact <= s3_valid;
      if (s3_valid) begin
        octrl                 <= s3_ctrl;
        output_memory_address <= s3_addr;
        output_A              <= {ya_i, ya_r};
        output_B              <= {yb_i, yb_r};
      end
    end
  end

  // Sticky flags.
  // clear_flags wins over a set in the same cycle.
  // overflow rises together with the oact of the offending beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      stage_err <= 1'b0;
    end else if (clear_flags) begin
      overflow  <= 1'b0;
      stage_err <= 1'b0;
    end else begin
      if (iact && !stage_ok) begin
        stage_err <= 1'b1;
      end
      if (s3_valid && any_clip) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_butterfly_core_pipelined.sv
// Testbench for butterfly_core_pipelined.
//
// Stimulus is issued beat by beat. Each expected result goes into a
// scoreboard queue, either from hand-derived constants or from a plain
// integer complex-arithmetic model. A separate monitor pops and compares
// whenever oact is high, and also checks the cycle of arrival.
module tb_butterfly_core_pipelined;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int BW = 4;
  localparam int AW = N - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [BW-1:0]     fft_stage = '0;
  logic [N-1:0]      scale_mask = '0;
  logic              inverse = 1'b0;
  logic              clear_flags = 1'b0;
  logic              iact = 1'b0;
  logic [1:0]        ictrl = '0;
  logic [AW-1:0]     input_memory_address = '0;
  logic [2*DW-1:0]   input_A = '0;
  logic [2*DW-1:0]   input_B = '0;
  logic [DW-1:0]     twiddle_real = '0;
  logic [DW-1:0]     twiddle_imag = '0;
  logic              oact;
  logic [1:0]        octrl;
  logic [AW-1:0]     output_memory_address;
  logic [2*DW-1:0]   output_A;
  logic [2*DW-1:0]   output_B;
  logic              overflow;
  logic              stage_err;

  butterfly_core_pipelined #(.FFT_N(N), .FFT_DW(DW), .STAGE_COUNT_BW(BW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .fft_stage             (fft_stage),
    .scale_mask            (scale_mask),
    .inverse               (inverse),
    .clear_flags           (clear_flags),
    .iact                  (iact),
    .ictrl                 (ictrl),
    .input_memory_address  (input_memory_address),
    .input_A               (input_A),
    .input_B               (input_B),
    .twiddle_real          (twiddle_real),
    .twiddle_imag          (twiddle_imag),
    .oact                  (oact),
    .octrl                 (octrl),
    .output_memory_address (output_memory_address),
    .output_A              (output_A),
    .output_B              (output_B),
    .overflow              (overflow),
    .stage_err             (stage_err)
  );

  typedef struct {
    int              cyc;
    logic [1:0]      ctrl;
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] a;
    logic [2*DW-1:0] b;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cycle = 0;
  int    oact_cycles = 0;
  int    first_oact = -1;

  always #5 clk = ~clk;

  // Free-running cycle count, one per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  // Safety net in case the bench ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d required completion", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  // Rounds a raw product sum back to the data scale (floor after bias).
  function automatic longint roundProd(input longint x);
    return (x + (longint'(1) <<< (DW - 2))) >>> (DW - 1);
  endfunction

  // Optional halving (round half up), then saturate or wrap to DW bits.
  function automatic logic [DW-1:0] narrowModel(input longint x, input bit sc);
    longint v;
    v = sc ? ((x + 1) >>> 1) : x;
`ifdef BUTTERFLY_SAT_EN
    if (v > (longint'(1) <<< (DW - 1)) - 1) v = (longint'(1) <<< (DW - 1)) - 1;
    if (v < -(longint'(1) <<< (DW - 1))) v = -(longint'(1) <<< (DW - 1));
`endif
    return DW'(v);
  endfunction

  // Drives one beat just after a rising edge. With push_model set, the
  // reference result is queued for the monitor.
  task automatic applyStimulus(input int stage, input logic [N-1:0] mask, input bit inv,
                               input logic [1:0] ctrl, input logic [AW-1:0] addr,
                               input logic signed [DW-1:0] ar, input logic signed [DW-1:0] ai,
                               input logic signed [DW-1:0] br, input logic signed [DW-1:0] bi,
                               input logic signed [DW-1:0] wr, input logic signed [DW-1:0] wi,
                               input bit push_model);
    longint wie, pr, pim, p_r, p_i;
    logic [3:0] si;
    bit sc;
    beat_t e;
    @(posedge clk);
    #1;
    iact                 = 1'b1;
    fft_stage            = BW'(stage);
    scale_mask           = mask;
    inverse              = inv;
    ictrl                = ctrl;
    input_memory_address = addr;
    input_A              = {ai, ar};
    input_B              = {bi, br};
    twiddle_real         = wr;
    twiddle_imag         = wi;
    if (push_model) begin
      si  = 4'(stage);
      sc  = mask[si];
      wie = inv ? -longint'(wi) : longint'(wi);
      pr  = longint'(br) * longint'(wr) - longint'(bi) * wie;
      pim = longint'(br) * wie + longint'(bi) * longint'(wr);
      p_r = roundProd(pr);
      p_i = roundProd(pim);
      e.cyc  = cycle + 4;
      e.ctrl = ctrl;
      e.addr = addr;
      e.a    = {narrowModel(longint'(ai) + p_i, sc), narrowModel(longint'(ar) + p_r, sc)};
      e.b    = {narrowModel(longint'(ai) - p_i, sc), narrowModel(longint'(ar) - p_r, sc)};
      exp_q.push_back(e);
    end
  endtask

  // Queues a hand-derived result for the beat just driven.
  task automatic pushHand(input logic [1:0] ctrl, input logic [AW-1:0] addr,
                          input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                          input logic [DW-1:0] br, input logic [DW-1:0] bi);
    beat_t e;
    e.cyc  = cycle + 4;
    e.ctrl = ctrl;
    e.addr = addr;
    e.a    = {ai, ar};
    e.b    = {bi, br};
    exp_q.push_back(e);
  endtask

  task automatic goIdle();
    @(posedge clk);
    #1;
    iact = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic pulseClear();
    @(posedge clk);
    #1;
    clear_flags = 1'b1;
    @(posedge clk);
    #1;
    clear_flags = 1'b0;
  endtask

  // Monitor: compares every presented output beat against the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset && oact) begin
        oact_cycles++;
        if (first_oact < 0) first_oact = cycle;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_oact: got oact=1 at cycle %0d required oact=0", cycle);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_cycle", 64'(cycle), 64'(e.cyc));
          checkOutput("beat_A", 64'(output_A), 64'(e.a));
          checkOutput("beat_B", 64'(output_B), 64'(e.b));
          checkOutput("beat_sideband", 64'({octrl, output_memory_address}),
                      64'({e.ctrl, e.addr}));
        end
      end
    end
  end

  initial begin
    int start_cyc;
    $display("[TB] start");

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_oact", 64'(oact), 64'(0));
    checkOutput("rst_octrl", 64'(octrl), 64'(0));
    checkOutput("rst_addr", 64'(output_memory_address), 64'(0));
    checkOutput("rst_A", 64'(output_A), 64'(0));
    checkOutput("rst_B", 64'(output_B), 64'(0));
    checkOutput("rst_overflow", 64'(overflow), 64'(0));
    checkOutput("rst_stage_err", 64'(stage_err), 64'(0));
    reset = 1'b0;

    // Identity twiddle: A'=(1300,-1600), B'=(700,-2400).
    applyStimulus(0, '0, 1'b0, 2'd2, 9'h15A, 16'sd1000, -16'sd2000, 16'sd300, 16'sd400,
                  16'sd32767, 16'sd0, 1'b0);
    pushHand(2'd2, 9'h15A, 16'd1300, -16'sd1600, 16'd700, -16'sd2400);
    // Inverse with stage-3 scaling: A'=(-8192,0), B'=(8192,0).
    applyStimulus(3, 10'b0000001000, 1'b1, 2'd1, 9'h033, 16'sd0, 16'sd0, 16'sd0, 16'sd16384,
                  16'sd0, 16'sh8000, 1'b0);
    pushHand(2'd1, 9'h033, -16'sd8192, 16'd0, 16'd8192, 16'd0);
    goIdle();
    waitDrain();
    checkOutput("no_overflow", 64'(overflow), 64'(0));

    // Overflow: A' real = 32767 + 32766 is out of range.
    applyStimulus(1, '0, 1'b0, 2'd3, 9'h1FF, 16'sd32767, 16'sd0, 16'sd32767, 16'sd0,
                  16'sd32767, 16'sd0, 1'b0);
`ifdef BUTTERFLY_SAT_EN
    pushHand(2'd3, 9'h1FF, 16'd32767, 16'd0, 16'd1, 16'd0);
`else
    pushHand(2'd3, 9'h1FF, 16'hFFFD, 16'd0, 16'd1, 16'd0);
`endif
    goIdle();
    waitDrain();
    checkOutput("overflow_set", 64'(overflow), 64'(1));
    pulseClear();
    checkOutput("overflow_cleared", 64'(overflow), 64'(0));

    // Streaming: 64 back-to-back random beats.
    oact_cycles = 0;
    first_oact  = -1;
    start_cyc   = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(int'($urandom_range(0, N - 1)), N'($urandom), 1'($urandom), 2'($urandom),
                    AW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                    DW'($urandom), DW'($urandom), DW'($urandom), 1'b1);
      if (i == 0) start_cyc = cycle;
    end
    goIdle();
    waitDrain();
    checkOutput("stream_oact_cycles", 64'(oact_cycles), 64'(64));
    checkOutput("stream_first_oact", 64'(first_oact), 64'(start_cyc + 4));

    pulseClear();
    checkOutput("flags_cleared", 64'({overflow, stage_err}), 64'(0));

    // Bad stage: dropped, stage_err raised.
    applyStimulus(N, '1, 1'b0, 2'd1, 9'h0AA, 16'sd5, 16'sd5, 16'sd5, 16'sd5,
                  16'sd100, 16'sd100, 1'b0);
    goIdle();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("stage_err_set", 64'(stage_err), 64'(1));

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i, '0, 1'b0, 2'd3, AW'(i + 1), 16'sd1234, 16'sd77, 16'sd900, -16'sd300,
                    16'sd20000, 16'sd9000, 1'b0);
    end
    goIdle();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_oact", 64'(oact), 64'(0));
    checkOutput("midrst_octrl", 64'(octrl), 64'(0));
    checkOutput("midrst_addr", 64'(output_memory_address), 64'(0));
    checkOutput("midrst_A", 64'(output_A), 64'(0));
    checkOutput("midrst_B", 64'(output_B), 64'(0));
    checkOutput("midrst_flags", 64'({overflow, stage_err}), 64'(0));
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (8) @(posedge clk);

    // First beat after reset release.
    applyStimulus(5, 10'b0000100000, 1'b1, 2'd2, 9'h101, -16'sd4000, 16'sd2500, 16'sd12000,
                  -16'sd7000, 16'sd23170, -16'sd23170, 1'b1);
    goIdle();
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
